// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory load/store unit.
package dmem_pkg;

  localparam int DMEM_DEPTH = 128;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

  // Size/alignment legality only; the range check needs DEPTH and lives in the LSU.
  function automatic logic size_illegal(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      SZ_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian lane extraction for loads and lane merging for sub-word stores.
module dmem_lane
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  size_e            i_size,
  input  logic [1:0]       i_lane,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_merged
);

  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_lane;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_ins;

  always_comb begin
    w_shamt = (i_size == SZ_HALF) ? {i_lane[1], 4'b0000} : {i_lane, 3'b000};
    w_lane  = i_word >> w_shamt;
    w_mask  = '1;
    o_load  = w_lane;
    case (i_size)
      SZ_BYTE: begin
        w_mask = WIDTH'(8'hFF) << w_shamt;
        o_load = {{(WIDTH-8){i_signed & w_lane[7]}}, w_lane[7:0]};
      end
      SZ_HALF: begin
        w_mask = WIDTH'(16'hFFFF) << w_shamt;
        o_load = {{(WIDTH-16){i_signed & w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        w_mask = '1;
        o_load = w_lane;
      end
    endcase
    w_ins    = i_wdata << w_shamt;
    o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline and a combinational-read data RAM;
// sub-word stores are done as read-modify-write.
//
//   state  | meaning
//   IDLE   | ready for a request, RAM address parked at 0
//   LOAD   | RAM word on mem_dout, extracted lane captured
//   STORE  | single-cycle full-word write
//   RMW_RD | read the target word and merge the store lane
//   RMW_WR | write the merged word back
//   RESP   | response held until the consumer takes it
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int WIDTH = 32,
  parameter int BITS  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [BITS-1:0]  req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_we,
  output logic [BITS-1:0]  mem_adr,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  state_e           r_state;
  state_e           w_next;
  size_e            r_size;
  logic             r_signed;
  logic [1:0]       r_lane;
  logic [BITS-1:0]  r_idx;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_merged;
  logic             r_err;

  logic             w_accept;
  logic             w_err;
  logic [BITS-1:0]  w_idx;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_merged;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_idx     = req_addr >> 2;
  assign w_err     = size_illegal(size_e'(req_size), req_addr[1:0]) || (w_idx >= BITS'(DEPTH));

  dmem_lane #(.WIDTH(WIDTH)) u_lane (
    .i_word   (mem_dout),
    .i_size   (r_size),
    .i_lane   (r_lane),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_lane   <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merged <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_size   <= size_e'(req_size);
        r_signed <= req_signed;
        r_lane   <= req_addr[1:0];
        r_idx    <= w_idx;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
        r_err    <= w_err;
      end
      if (r_state == LOAD)   r_rdata  <= w_load;
      if (r_state == RMW_RD) r_merged <= w_merged;
    end
  end

  // Write strobes are gated by rst_n so a reset landing on a write cycle never commits it.
  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    mem_din   = '0;
    mem_adr   = r_idx;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (r_state)
      IDLE: begin
        mem_adr = '0;
        if (w_accept) begin
          if (w_err)                              w_next = RESP;
          else if (!req_we)                       w_next = LOAD;
          else if (size_e'(req_size) == SZ_WORD)  w_next = STORE;
          else                                    w_next = RMW_RD;
        end
      end
      LOAD:   w_next = RESP;
      STORE: begin
        mem_we  = rst_n;
        mem_din = rst_n ? r_wdata : '0;
        w_next  = RESP;
      end
      RMW_RD: w_next = RMW_WR;
      RMW_WR: begin
        mem_we  = rst_n;
        mem_din = rst_n ? r_merged : '0;
        w_next  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = r_rdata;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-level reference model, per-cycle output compare, directed and random requests.
module tb_dmem_lsu;

  localparam int DEPTH = 128;
  localparam int WIDTH = 32;
  localparam int BITS  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_we = 1'b0;
  logic [1:0]       req_size = 2'b00;
  logic             req_signed = 1'b0;
  logic [BITS-1:0]  req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             rsp_ready = 1'b0;
  logic             req_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             mem_we;
  logic [BITS-1:0]  mem_adr;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          init_done = 1'b0;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // Expectation for the request in flight, set by the driver.
  bit          chk_en = 1'b0;
  bit          outstanding = 1'b0;
  int          t_acc = 0;
  int          e_lat = 0;
  bit          e_err = 1'b0;
  bit          e_wr = 1'b0;
  logic [31:0] e_rdata = '0;
  logic [31:0] e_wdat = '0;
  logic [31:0] e_idx = '0;
  bit          cmp_v, cmp_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BITS(BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_A5A5;
  endfunction

  assign mem_dout = (mem_adr < DEPTH) ? ram[mem_adr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (mem_we && mem_adr < DEPTH) begin
      ram[mem_adr[6:0]] <= mem_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: what a request must do, from byte-addressed memory semantics.
  function automatic void model(input bit we, input logic [1:0] sz, input bit sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output bit err, output int lat, output logic [31:0] rd,
                                output bit wr, output logic [31:0] nw);
    logic [31:0] idx;
    logic [31:0] w;
    int          k;
    idx = a / 4;
    k   = int'(a % 4);
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && k != 0) || (idx >= DEPTH);
    rd  = '0;
    wr  = 1'b0;
    nw  = '0;
    lat = 1;
    if (!err) begin
      w = ref_mem[idx[6:0]];
      if (!we) begin
        lat = 2;
        if (sz == 2'd0) begin
          rd = (w >> (8 * k)) & 32'hFF;
          if (sg && rd[7]) rd = rd | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          rd = (w >> (16 * (k / 2))) & 32'hFFFF;
          if (sg && rd[15]) rd = rd | 32'hFFFF_0000;
        end else begin
          rd = w;
        end
      end else begin
        wr = 1'b1;
        if (sz == 2'd0) begin
          lat = 3;
          w[8*k +: 8] = wd[7:0];
        end else if (sz == 2'd1) begin
          lat = 3;
          w[16*(k/2) +: 16] = wd[15:0];
        end else begin
          lat = 2;
          w = wd;
        end
        nw = w;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_v = outstanding && (cyc >= t_acc + e_lat);
      cmp_w = outstanding && e_wr && (cyc == t_acc + e_lat - 1);
      chk("rsp_valid", 32'(rsp_valid), 32'(cmp_v));
      chk("req_ready", 32'(req_ready), 32'(!outstanding || cyc == t_acc));
      chk("mem_we", 32'(mem_we), 32'(cmp_w));
      if (cmp_v) begin
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_rdata", rsp_rdata, e_rdata);
      end
      if (mem_we) begin
        chk("mem_adr_wr", mem_adr, e_idx);
        chk("mem_din_wr", mem_din, e_wdat);
      end else begin
        chk("mem_din_idle", mem_din, 32'h0);
      end
      if (req_ready) chk("mem_adr_idle", mem_adr, 32'h0);
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_req(input bit we, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] g_rd, output logic g_err, output int g_lat);
    bit          err, wr;
    int          lat, n;
    logic [31:0] rd, nw;
    model(we, sz, sg, a, wd, err, lat, rd, wr, nw);
    e_err = err; e_lat = lat; e_rdata = rd; e_wr = wr; e_wdat = nw; e_idx = a >> 2;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    t_acc = cyc;
    outstanding = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    g_lat = -1;
    n = 0;
    while (g_lat < 0 && n < 8) begin
      if (rsp_valid) g_lat = cyc - t_acc;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    g_rd  = rsp_rdata;
    g_err = rsp_err;
    if (g_lat < 0) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: no rsp_valid within 8 cycles of acceptance at cycle %0d", t_acc);
    end
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    outstanding = 1'b0;
    if (wr) ref_mem[e_idx[6:0]] = nw;
  endtask

  initial begin
    logic [31:0] g_rd, a, saved;
    logic        g_err;
    int          g_lat;
    logic [1:0]  sz;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 init_done = 1'b1;

    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'h1);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Word store then sub-word loads of the same word
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, g_rd, g_err, g_lat);
    chk("sw_lat", 32'(g_lat), 32'd2);
    chk("sw_err", 32'(g_err), 32'h0);
    chk("sw_ram4", ram[4], 32'hDEAD_BEEF);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, g_rd, g_err, g_lat);
    chk("lb_rdata", g_rd, 32'hFFFF_FFDE);
    chk("lb_lat", 32'(g_lat), 32'd2);
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, g_rd, g_err, g_lat);
    chk("lbu_rdata", g_rd, 32'h0000_00DE);

    // Half store via read-modify-write
    run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, 0, g_rd, g_err, g_lat);
    chk("sh_lat", 32'(g_lat), 32'd3);
    chk("sh_ram4", ram[4], 32'h1234_BEEF);

    // Errors: misaligned word, out of range
    run_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0, g_rd, g_err, g_lat);
    chk("lw_mis_err", 32'(g_err), 32'h1);
    chk("lw_mis_lat", 32'(g_lat), 32'd1);
    chk("lw_mis_rdata", g_rd, 32'h0);
    run_req(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, 0, g_rd, g_err, g_lat);
    chk("lw_oor_err", 32'(g_err), 32'h1);
    chk("lw_oor_lat", 32'(g_lat), 32'd1);
    run_req(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF, 0, g_rd, g_err, g_lat);
    chk("ill_size_err", 32'(g_err), 32'h1);

    // Back-pressure: response held while rsp_ready is low
    run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5, g_rd, g_err, g_lat);
    chk("lh_rdata", g_rd, 32'hFFFF_BEEF);

    for (int i = 0; i < 400; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 4 * DEPTH + 15));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              int'($urandom_range(0, 2)), g_rd, g_err, g_lat);
    end

    // Reset during RMW_RD of a byte store must leave memory untouched
    chk_en = 1'b0;
    saved = ref_mem[8];
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h21; req_wdata = ~saved;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmw_rst_we0", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmw_rst_we1", 32'(mem_we), 32'h0);
    chk("rmw_rst_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rmw_rst_ready", 32'(req_ready), 32'h1);
    chk("rmw_rst_we2", 32'(mem_we), 32'h0);
    chk("rmw_rst_ram", ram[8], saved);
    @(posedge clk); #1;
    chk_en = 1'b1;
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, g_rd, g_err, g_lat);
    chk("post_rst_lw", g_rd, saved);

    for (int i = 0; i < DEPTH; i++) chk("ram_final", ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
